sal_cmd_sched: RTL

Command scheduler between the per-bank controllers and the shared DFI command bus of the DDR2 controller. Each cycle it picks at most one pending bank command, enforcing the inter-bank timing constraints tRRD, tCCD, tWTR and tRTW. It grants the winning bank and drives the registered DDR2 command onto the DFI control signals. Timing values come from the configuration block as static inputs.

---
 rtl/sal_cmd_sched.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/sal_cmd_sched.sv
// sal_cmd_sched: DDR2 command scheduler between the per-bank controllers and
// the shared DFI command bus. Each cycle at most one pending bank command is
// granted, subject to the inter-bank tRRD / tCCD / tWTR / tRTW constraints.
// The granted command is registered onto the DFI control signals one cycle
// after the grant.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   req_i [BK_CNT]        per-bank command valid
//   cmd_i [2*BK_CNT]      per-bank command (00 ACT, 01 RD, 10 WR, 11 PRE)
//   addr_i[ADDR_W*BK_CNT] per-bank row / column address
//   gnt_o [BK_CNT]        one-hot grant, combinational
//   t_rrd_i, t_ccd_i, t_wtr_i, t_rtw_i, t_faw_i  static timing values
//   dfi_cs_n_o, dfi_ras_n_o, dfi_cas_n_o, dfi_we_n_o, dfi_bank_o, dfi_address_o
//
// Optional feature: define SAL_SCHED_FAW_EN to build the four-activate-window
// history; otherwise t_faw_i is ignored.
module sal_cmd_sched #(
  parameter int unsigned BK_CNT = 8,
  parameter int unsigned BA_W   = 3,
  parameter int unsigned ADDR_W = 14,
  parameter int unsigned TW     = 5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [BK_CNT-1:0]        req_i,
  input  logic [2*BK_CNT-1:0]      cmd_i,
  input  logic [ADDR_W*BK_CNT-1:0] addr_i,
  output logic [BK_CNT-1:0]        gnt_o,
  input  logic [TW-1:0]            t_rrd_i,
  input  logic [TW-1:0]            t_ccd_i,
  input  logic [TW-1:0]            t_wtr_i,
  input  logic [TW-1:0]            t_rtw_i,
  input  logic [TW-1:0]            t_faw_i,
  output logic                     dfi_cs_n_o,
  output logic                     dfi_ras_n_o,
  output logic                     dfi_cas_n_o,
  output logic                     dfi_we_n_o,
  output logic [BA_W-1:0]          dfi_bank_o,
  output logic [ADDR_W-1:0]        dfi_address_o
);

  typedef enum logic [1:0] {
    CMD_ACT = 2'b00,
    CMD_RD  = 2'b01,
    CMD_WR  = 2'b10,
    CMD_PRE = 2'b11
  } cmd_e;

  // active holds grants off until the first edge after reset release, so a
  // request held through reset is never granted while rst_n is low.
  logic              active;
  logic [BA_W-1:0]   ptr;
  logic [TW-1:0]     cnt_rrd, cnt_ccd, cnt_wtr, cnt_rtw;
  logic              faw_ok;
  logic [BK_CNT-1:0] cas_elig, oth_elig, pick_vec;
  logic              found;
  logic [BA_W-1:0]   sel, cand;
  cmd_e              sel_cmd;
  logic              issue;
  logic              issue_act;

  function automatic logic [TW-1:0] tm1(input logic [TW-1:0] t);
    return (t == '0) ? '0 : t - TW'(1);
  endfunction

  function automatic logic [TW-1:0] dec(input logic [TW-1:0] c);
    return (c == '0) ? '0 : c - TW'(1);
  endfunction

  always_comb begin
    cas_elig = '0;
    oth_elig = '0;
    for (int unsigned b = 0; b < BK_CNT; b++) begin
      case (cmd_e'(cmd_i[2*b +: 2]))
        CMD_ACT: oth_elig[b] = req_i[b] && (cnt_rrd == '0) && faw_ok;
        CMD_RD:  cas_elig[b] = req_i[b] && (cnt_ccd == '0) && (cnt_wtr == '0);
        CMD_WR:  cas_elig[b] = req_i[b] && (cnt_ccd == '0) && (cnt_rtw == '0);
        default: oth_elig[b] = req_i[b];
      endcase
    end
    // Any eligible CAS command wins over ACT/PRE; round-robin within the class.
    pick_vec = (|cas_elig) ? cas_elig : oth_elig;
    found = 1'b0;
    sel   = '0;
    cand  = '0;
    for (int unsigned i = 0; i < BK_CNT; i++) begin
      cand = ptr + BA_W'(i);
      if (!found && pick_vec[cand]) begin
        found = 1'b1;
        sel   = cand;
      end
    end
    issue     = active && found;
    sel_cmd   = cmd_e'(cmd_i[{sel, 1'b0} +: 2]);
    issue_act = issue && (sel_cmd == CMD_ACT);
    gnt_o     = '0;
    if (issue) gnt_o[sel] = 1'b1;
  end

`ifdef SAL_SCHED_FAW_EN
  localparam int unsigned CW = TW + 2;

  logic [CW-1:0] cyc;
  logic [CW-1:0] ts   [4];
  logic [CW-1:0] age  [4];
  logic [3:0]    ts_vld;
  logic [3:0]    live;

  // Entries older than half the counter range can never block (t_faw_i is
  // narrower), so retire them before the timestamp subtraction can wrap.
  always_comb begin
    for (int unsigned i = 0; i < 4; i++) begin
      age[i]  = cyc - ts[i];
      live[i] = ts_vld[i] && !age[i][CW-1];
    end
    faw_ok = !(live[3] && (age[3] < {2'b00, t_faw_i}));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc    <= '0;
      ts_vld <= '0;
      for (int unsigned i = 0; i < 4; i++) ts[i] <= '0;
    end else begin
      cyc <= cyc + CW'(1);
      if (issue_act) begin
        ts[0]  <= cyc;
        ts[1]  <= ts[0];
        ts[2]  <= ts[1];
        ts[3]  <= ts[2];
        ts_vld <= {live[2:0], 1'b1};
      end else begin
        ts_vld <= live;
      end
    end
  end
`else
  logic faw_unused;
  assign faw_unused = ^t_faw_i;
  assign faw_ok     = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active        <= 1'b0;
      ptr           <= '0;
      cnt_rrd       <= '0;
      cnt_ccd       <= '0;
      cnt_wtr       <= '0;
      cnt_rtw       <= '0;
      dfi_cs_n_o    <= 1'b1;
      dfi_ras_n_o   <= 1'b1;
      dfi_cas_n_o   <= 1'b1;
      dfi_we_n_o    <= 1'b1;
      dfi_bank_o    <= '0;
      dfi_address_o <= '0;
    end else begin
      active  <= 1'b1;
      cnt_rrd <= issue_act ? tm1(t_rrd_i) : dec(cnt_rrd);
      cnt_ccd <= (issue && (sel_cmd == CMD_RD || sel_cmd == CMD_WR)) ? tm1(t_ccd_i) : dec(cnt_ccd);
      cnt_rtw <= (issue && sel_cmd == CMD_RD) ? tm1(t_rtw_i) : dec(cnt_rtw);
      cnt_wtr <= (issue && sel_cmd == CMD_WR) ? tm1(t_wtr_i) : dec(cnt_wtr);
      if (issue) begin
        ptr        <= sel + BA_W'(1);
        dfi_cs_n_o <= 1'b0;
        case (sel_cmd)
          CMD_ACT: {dfi_ras_n_o, dfi_cas_n_o, dfi_we_n_o} <= 3'b011;
          CMD_RD:  {dfi_ras_n_o, dfi_cas_n_o, dfi_we_n_o} <= 3'b101;
          CMD_WR:  {dfi_ras_n_o, dfi_cas_n_o, dfi_we_n_o} <= 3'b100;
          default: {dfi_ras_n_o, dfi_cas_n_o, dfi_we_n_o} <= 3'b010;
        endcase
        dfi_bank_o    <= sel;
        dfi_address_o <= addr_i[sel*ADDR_W +: ADDR_W];
      end else begin
        dfi_cs_n_o  <= 1'b1;
        dfi_ras_n_o <= 1'b1;
        dfi_cas_n_o <= 1'b1;
        dfi_we_n_o  <= 1'b1;
      end
    end
  end

endmodule
